// File: rtl/zbus_master.sv
// Z80-style ZX-bus cycle initiator: one req/ack handshake becomes one IO or memory
// read/write cycle (T1, T2, TW*, T3, HOLD) with WAIT handling and a wait-state timeout.
module zbus_master #(
    parameter int TDIV     = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_io,
    input  logic        req_rnw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        claimed,
    output logic        timeout,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        zmreq_n,
    output logic        ziorq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        zwait_n,
    input  logic        ziorqge
);

    localparam int              TCW   = $clog2(TDIV);
    localparam logic [TCW-1:0]  TLAST = TCW'(TDIV - 1);
    localparam logic [7:0]      WMAX  = 8'(WAIT_MAX);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_HOLD} state_t;

    state_t          state_q;
    logic [TCW-1:0]  tcnt_q;
    logic [7:0]      wcnt_q;
    logic            io_q, rnw_q;
    logic            busy_q, ack_q, claimed_q, timeout_q, zd_oe_q;
    logic [7:0]      rdata_q, zd_out_q;
    logic [15:0]     za_q;
    logic            zmreq_n_q, ziorq_n_q, zrd_n_q, zwr_n_q;
    logic            tlast;

    assign tlast = (tcnt_q == TLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            wcnt_q    <= '0;
            io_q      <= 1'b0;
            rnw_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            claimed_q <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            za_q      <= '0;
            zd_out_q  <= '0;
            zd_oe_q   <= 1'b0;
            zmreq_n_q <= 1'b1;
            ziorq_n_q <= 1'b1;
            zrd_n_q   <= 1'b1;
            zwr_n_q   <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            if (state_q inside {S_T1, S_T2, S_TW, S_T3})
                tcnt_q <= tlast ? '0 : tcnt_q + 1'b1;
            else
                tcnt_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        io_q      <= req_io;
                        rnw_q     <= req_rnw;
                        za_q      <= req_addr;
                        if (!req_rnw)
                            zd_out_q <= req_wdata;
                        zd_oe_q   <= !req_rnw;
                        busy_q    <= 1'b1;
                        claimed_q <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= S_T1;
                    end
                end
                S_T1: begin
                    if (tlast) begin
                        zmreq_n_q <= io_q;
                        ziorq_n_q <= !io_q;
                        zrd_n_q   <= !rnw_q;
                        zwr_n_q   <= rnw_q;
                        state_q   <= S_T2;
                    end
                end
                S_T2: begin
                    // IO cycles always insert one wait state, regardless of WAIT
                    if (tlast) begin
                        wcnt_q  <= '0;
                        state_q <= (io_q || !zwait_n) ? S_TW : S_T3;
                    end
                end
                S_TW: begin
                    if (tlast) begin
                        if (zwait_n) begin
                            state_q <= S_T3;
                        end else if (wcnt_q == WMAX) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_T3;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_T3: begin
                    if (tlast) begin
                        if (rnw_q)
                            rdata_q <= zd_in;
                        claimed_q <= io_q && rnw_q && ziorqge;
                        zmreq_n_q <= 1'b1;
                        ziorq_n_q <= 1'b1;
                        zrd_n_q   <= 1'b1;
                        zwr_n_q   <= 1'b1;
                        ack_q     <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    zd_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign claimed = claimed_q;
    assign timeout = timeout_q;
    assign za      = za_q;
    assign zd_out  = zd_out_q;
    assign zd_oe   = zd_oe_q;
    assign zmreq_n = zmreq_n_q;
    assign ziorq_n = ziorq_n_q;
    assign zrd_n   = zrd_n_q;
    assign zwr_n   = zwr_n_q;

endmodule

// File: tb/tb_zbus_master.sv
// Directed bench for zbus_master: table of bus cycles with hand-computed latency, strobe
// and data results, plus reset-mid-cycle and back-to-back sequences.
module tb_zbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_io, req_rnw;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy, ack, claimed, timeout, zd_oe;
    logic [7:0]  rdata, zd_out, zd_in;
    logic [15:0] za;
    logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
    logic        zwait_n, ziorqge;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zbus_master #(.TDIV(4), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_io(req_io), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .ack(ack),
        .rdata(rdata), .claimed(claimed), .timeout(timeout), .za(za),
        .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in), .zmreq_n(zmreq_n),
        .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zwait_n(zwait_n),
        .ziorqge(ziorqge)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus-rule monitor: strobes never move with za, zd_oe never rises under a read strobe
    logic        rst_e;
    logic [15:0] za_p;
    logic [3:0]  st_p;
    logic        oe_p;
    int          viol = 0;
    int          ack_cnt = 0;
    always @(posedge clk) begin
        rst_e <= rst;
        #1;
        if (rst_e === 1'b0) begin
            if (za != za_p && {zmreq_n, ziorq_n, zrd_n, zwr_n} != st_p) viol <= viol + 1;
            else if (zd_oe && !oe_p && !zrd_n) viol <= viol + 1;
        end
        if (ack) ack_cnt <= ack_cnt + 1;
        za_p <= za;
        st_p <= {zmreq_n, ziorq_n, zrd_n, zwr_n};
        oe_p <= zd_oe;
    end

    typedef struct {
        logic        io, rnw;
        logic [15:0] addr;
        logic [7:0]  wdata, zd;
        logic        ge;
        int          rel;     // first cycle (after accept) at which zwait_n is 1 and zd_in valid
        int          lat, low;
        logic [3:0]  mask;    // strobes seen low: {mreq, iorq, rd, wr}
        logic [7:0]  rdata;
        logic        cl, to;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input string tag);
        int n, lat, low;
        logic [3:0] mask;
        @(negedge clk);
        req_io = v.io; req_rnw = v.rnw; req_addr = v.addr; req_wdata = v.wdata;
        ziorqge = v.ge; zwait_n = 1'b1; zd_in = (v.rel == 0) ? v.zd : 8'hEE;
        req = 1'b1;
        n = 0; lat = -1; low = 0; mask = 4'b0000;
        while (lat < 0 && n < 200) begin
            @(negedge clk);
            n++;
            req = 1'b0;
            if (ack) begin
                lat = n;
                check({tag, " za"}, 32'(za), 32'(v.addr));
                check({tag, " zd_oe"}, 32'(zd_oe), 32'(!v.rnw));
                if (!v.rnw) check({tag, " zd_out"}, 32'(zd_out), 32'(v.wdata));
                check({tag, " rdata"}, 32'(rdata), 32'(v.rdata));
                check({tag, " claimed"}, 32'(claimed), 32'(v.cl));
                check({tag, " timeout"}, 32'(timeout), 32'(v.to));
            end else begin
                if (!zrd_n || !zwr_n) low++;
                mask |= ~{zmreq_n, ziorq_n, zrd_n, zwr_n};
                zwait_n = (n >= v.rel);
                zd_in   = (n >= v.rel) ? v.zd : 8'hEE;
            end
        end
        zwait_n = 1'b1;
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " strobe_low_clks"}, 32'(low), 32'(v.low));
        check({tag, " strobe_mask"}, 32'(mask), 32'(v.mask));
        @(negedge clk);
        check({tag, " idle_after"}, {27'd0, busy, zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe},
              {27'd0, 1'b0, 4'b1111, 1'b0});
        $display("[TB] %s io=%0d rnw=%0d addr=%h lat=%0d rdata=%h cl=%0d to=%0d",
                 tag, v.io, v.rnw, v.addr, lat, rdata, claimed, timeout);
    endtask

    initial begin
        int n, a0;
        rst = 1'b1; req = 1'b0; req_io = 1'b0; req_rnw = 1'b0; req_addr = 16'h0;
        req_wdata = 8'h0; zd_in = 8'h0; zwait_n = 1'b1; ziorqge = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 16'h4000, 8'h5A, 8'h00, 1'b0, 0,    13,  8, 4'b1001, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h80AB, 8'h00, 8'h3C, 1'b1, 0,    17, 12, 4'b0110, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h80FE, 8'h00, 8'hA5, 1'b1, 18,   25, 20, 4'b0110, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h99, 1'b1, 10,   17, 12, 4'b1010, 8'h99, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h00FE, 8'hC3, 8'h00, 1'b1, 0,    17, 12, 4'b0101, 8'h99, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h001F, 8'h00, 8'h77, 1'b0, 0,    17, 12, 4'b0110, 8'h77, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1000, 33, 28, 4'b1001, 8'h77, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h11, 1'b0, 0,    13,  8, 4'b1010, 8'h11, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset strobes", 32'({zmreq_n, ziorq_n, zrd_n, zwr_n}), 32'hF);
        check("reset za", 32'(za), 32'h0);
        check("reset zd", 32'({zd_out, zd_oe}), 32'h0);
        check("reset status", 32'({busy, ack, claimed, timeout, rdata}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while a memory write is in T2
        @(negedge clk);
        req_io = 1'b0; req_rnw = 1'b0; req_addr = 16'h2000; req_wdata = 8'hAA; req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        check("rstmid strobes_low", 32'({zmreq_n, zwr_n, zd_oe}), 32'b001);
        a0 = ack_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid strobes_high", 32'({zmreq_n, ziorq_n, zrd_n, zwr_n}), 32'hF);
        check("rstmid zd_oe_busy_ack", 32'({zd_oe, busy, ack}), 32'h0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid no_ack", 32'(ack_cnt), 32'(a0));
        check("rstmid idle", 32'(busy), 32'h0);
        $display("[TB] rst-mid-T2 strobes=%b zd_oe=%0d busy=%0d", {zmreq_n, zwr_n}, zd_oe, busy);

        // Back-to-back: req held high, IO write then memory read
        req_io = 1'b1; req_rnw = 1'b0; req_addr = 16'h00A0; req_wdata = 8'h3E; req = 1'b1;
        zd_in = 8'h6B;
        n = 0;
        while (!ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b first_lat", 32'(n), 32'd17);
        req_io = 1'b0; req_rnw = 1'b1; req_addr = 16'h5555;
        @(negedge clk);
        check("b2b idle_gap", 32'(busy), 32'h0);
        @(negedge clk);
        req = 1'b0;
        check("b2b second_accept", 32'({busy, za}), {15'd0, 1'b1, 16'h5555});
        n = 1;
        while (!ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b second_lat", 32'(n), 32'd13);
        check("b2b rdata", 32'(rdata), 32'h6B);
        $display("[TB] back-to-back second lat=%0d rdata=%h", n, rdata);

        repeat (2) @(negedge clk);
        check("bus rule violations", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
